// File: rtl/fetch.sv
// RV32I instruction fetch: owns the PC, issues one-outstanding word reads and buffers {pc, instr}
// for decode. Define FETCH_PREDICT_EN for static JAL/backward-branch prediction at push.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        req,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        pred_taken_out
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            imem_req_q, imem_req_d;
  logic [31:0]     imem_addr_q, imem_addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] fifo_pc_q    [BUF_DEPTH];
  logic [31:0] fifo_pc_d    [BUF_DEPTH];
  logic [31:0] fifo_instr_q [BUF_DEPTH];
  logic [31:0] fifo_instr_d [BUF_DEPTH];
  logic        fifo_pred_q  [BUF_DEPTH];
  logic        fifo_pred_d  [BUF_DEPTH];

  logic            push, pop, has_room;
  logic [CntW-1:0] count_next;
  logic [31:0]     next_pc;
  logic            pred;

  // Next PC for the word being returned this cycle
`ifdef FETCH_PREDICT_EN
  logic [6:0]  opcode;
  logic [31:0] j_imm, b_imm;
  always_comb begin
    opcode  = imem_rdata[6:0];
    j_imm   = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
    b_imm   = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
    if (opcode == 7'b1101111) begin
      next_pc = pc_q + j_imm;
      pred    = 1'b1;
    end else if (opcode == 7'b1100011 && imem_rdata[31]) begin
      next_pc = pc_q + b_imm;
      pred    = 1'b1;
    end
  end
`else
  always_comb begin
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
  end
`endif

  // A redirect voids both the pop and any returning word in the same cycle
  always_comb begin
    valid_out  = (count_q != '0);
    pop        = valid_out && !stall && !redirect;
    push       = (state_q == StBusy) && imem_ack && !redirect;
    count_next = count_q + CntW'(push) - CntW'(pop);
    has_room   = (count_next < CntW'(BUF_DEPTH));
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_addr_d  = imem_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_next;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pred_d  = fifo_pred_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      fifo_pc_d[wr_ptr_q]    = pc_q;
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pred_d[wr_ptr_q]  = pred;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_pc & ~32'h3;
      case (state_q)
        StIdle: begin
          state_d     = StBusy;
          imem_addr_d = pc_d;
        end
        StBusy, StDrop: begin
          // Only a completed read frees the bus for the new address
          if (imem_ack) begin
            state_d     = StBusy;
            imem_addr_d = pc_d;
          end else begin
            state_d = StDrop;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          if (has_room) begin
            state_d     = StBusy;
            imem_addr_d = pc_q;
          end
        end
        StBusy: begin
          if (imem_ack) begin
            pc_d = next_pc;
            if (has_room) begin
              imem_addr_d = next_pc;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDrop: begin
          if (imem_ack) begin
            state_d     = StBusy;
            imem_addr_d = pc_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    imem_req_d = (state_d != StIdle);
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
        fifo_pred_q[i]  <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pred_q  <= fifo_pred_d;
    end
  end

  always_comb begin
    imem_req       = imem_req_q;
    imem_addr      = imem_addr_q;
    instr_out      = valid_out ? fifo_instr_q[rd_ptr_q] : 32'h0;
    pc_out         = valid_out ? fifo_pc_q[rd_ptr_q] : 32'h0;
    pred_taken_out = valid_out && fifo_pred_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: zero-wait and latency memory model, stall, redirect, wrap, prediction.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        pred_taken_out;

  logic        zero_wait;
  int          lat;
  logic        ack_r;
  int          wait_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC  (32'h0000_0100),
    .BUF_DEPTH (2)
  ) u_dut (
    .req            (clk),
    .reset          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .pred_taken_out (pred_taken_out)
  );

  // Memory image: address shifted left by 2 (low opcode bits 00, never a branch), one branch at 0x10
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hFE00_0EE3;
    return {a[29:0], 2'b00};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = zero_wait ? imem_req : ack_r;

  // Latency memory: ack pulses after lat cycles of an outstanding request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r    <= 1'b0;
      wait_cnt <= 0;
    end else if (imem_req && !ack_r) begin
      if (wait_cnt == lat - 1) begin
        ack_r    <= 1'b1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic zw, input logic st);
    @(negedge clk);
    rst_n     = 1'b0;
    zero_wait = zw;
    stall     = st;
    redirect  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!valid_out && n < budget) begin
      step();
      n++;
    end
    check("valid_timeout", {31'h0, valid_out}, 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    zero_wait   = 1'b1;
    lat         = 3;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pred", {31'h0, pred_taken_out}, 32'h0);

    // Zero-wait streaming
    do_reset(1'b1, 1'b0);
    step();
    check("zw_req1", {31'h0, imem_req}, 32'h1);
    check("zw_addr1", imem_addr, 32'h100);
    check("zw_valid1", {31'h0, valid_out}, 32'h0);
    step();
    check("zw_addr2", imem_addr, 32'h104);
    check("zw_valid2", {31'h0, valid_out}, 32'h1);
    check("zw_pc2", pc_out, 32'h100);
    check("zw_instr2", instr_out, 32'h400);
    step();
    check("zw_addr3", imem_addr, 32'h108);
    check("zw_pc3", pc_out, 32'h104);
    check("zw_valid3", {31'h0, valid_out}, 32'h1);
    step();
    check("zw_addr4", imem_addr, 32'h10C);
    check("zw_pc4", pc_out, 32'h108);
    check("zw_instr4", instr_out, 32'h420);

    // Stall for 5 cycles: FIFO fills after 2 pushes, then fetch idles
    do_reset(1'b1, 1'b1);
    step();
    step();
    step();
    check("st_req_idle", {31'h0, imem_req}, 32'h0);
    check("st_head", pc_out, 32'h100);
    step();
    step();
    check("st_req_hold", {31'h0, imem_req}, 32'h0);
    check("st_head_hold", pc_out, 32'h100);
    stall = 1'b0;
    step();
    check("st_rel_pc1", pc_out, 32'h104);
    check("st_rel_req", {31'h0, imem_req}, 32'h1);
    check("st_rel_addr", imem_addr, 32'h108);
    step();
    check("st_rel_pc2", pc_out, 32'h108);
    check("st_rel_valid", {31'h0, valid_out}, 32'h1);

    // 3-cycle latency, redirect during the 2nd wait cycle
    lat = 3;
    do_reset(1'b0, 1'b0);
    step();
    check("lat_addr0", imem_addr, 32'h100);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("lat_stale_addr", imem_addr, 32'h100);
    check("lat_valid_flush", {31'h0, valid_out}, 32'h0);
    step();
    step();
    check("lat_new_addr", imem_addr, 32'h200);
    check("lat_drop_valid", {31'h0, valid_out}, 32'h0);
    wait_valid(20);
    check("lat_first_pc", pc_out, 32'h200);
    check("lat_first_instr", instr_out, 32'h800);

    // Redirect together with ack and stall
    do_reset(1'b1, 1'b1);
    step();
    step();
    check("ra_valid_pre", {31'h0, valid_out}, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("ra_flush", {31'h0, valid_out}, 32'h0);
    check("ra_addr", imem_addr, 32'h400);
    step();
    check("ra_pc", pc_out, 32'h400);
    check("ra_instr", instr_out, 32'h1000);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_next", imem_addr, 32'h0);
    check("wr_pc", pc_out, 32'hFFFF_FFFC);

    // Backward branch at 0x10
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    check("pr_addr", imem_addr, 32'h10);
    step();
    check("pr_pc", pc_out, 32'h10);
    check("pr_instr", instr_out, 32'hFE00_0EE3);
`ifdef FETCH_PREDICT_EN
    check("pr_next", imem_addr, 32'h0C);
    check("pr_taken", {31'h0, pred_taken_out}, 32'h1);
`else
    check("pr_next", imem_addr, 32'h14);
    check("pr_taken", {31'h0, pred_taken_out}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
